// File: rtl/text_renderer_pkg.sv
// Shared video constants and types for the character-cell text path.
package text_renderer_pkg;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned GLYPH_W  = 8;
  localparam logic [7:0]  SPACE_CHAR = 8'h20;

  typedef logic [11:0] rgb444_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;
endpackage

// File: rtl/text_renderer_if.sv
// Character-buffer write bus with ready handshake and clear request.
interface text_renderer_if #(
  parameter int ADDR_W = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              clear_req;

  modport master (output wr_en, wr_addr, wr_data, clear_req, input wr_ready);
  modport slave  (input wr_en, wr_addr, wr_data, clear_req, output wr_ready);
endinterface

// File: rtl/text_renderer_ram.sv
// Character buffer: one write port, one synchronous read-first read port, no reset.
module text_buffer_ram #(
  parameter int DEPTH  = 2400,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= (raddr <= LAST) ? mem[raddr] : '0;
    if (we && (waddr <= LAST))
      mem[waddr] <= wdata;
  end
endmodule

// File: rtl/text_renderer.sv
// Text-mode renderer: 3-stage raster pipeline feeding font_rom, blinking
// block cursor, and a sequencer that fills the buffer with spaces.
module text_renderer
  import text_renderer_pkg::*;
#(
  parameter int      COLS         = 80,
  parameter int      ROWS         = 30,
  parameter int      CHAR_H       = 16,
  parameter rgb444_t FG           = 12'hFFF,
  parameter rgb444_t BG           = 12'h000,
  parameter int      BLINK_FRAMES = 32,
  parameter int      ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  text_renderer_if.slave    wr,
  input  logic              cursor_en,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic [7:0]        char_code,
  output logic [3:0]        font_row,
  input  logic [7:0]        font_line,
  output rgb444_t           rgb,
  output logic              hsync_out,
  output logic              vsync_out
);
  localparam int DEPTH = COLS * ROWS;
  localparam int YB    = $clog2(CHAR_H);
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        CUR_ROW = 4'(CHAR_H - 2);
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready_q;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;
  logic              vs_prev;

  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

  logic [2:0]    x0, x1;
  logic [YB-1:0] y0;
  logic          von0, von1, hs0, hs1, vs0, vs1, hit0, hit1;
  logic          cursor_on, pix_bit;

  assign rd_addr = ADDR_W'((32'(pix_y) / CHAR_H) * COLS) + ADDR_W'(pix_x[9:3]);
  assign wr.wr_ready = ready_q;

  always_comb begin
    ram_we    = wr.wr_en && ready_q;
    ram_waddr = wr.wr_addr;
    ram_wdata = wr.wr_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = SPACE_CHAR;
    end
  end

  text_buffer_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_addr <= '0;
      ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (wr.clear_req) begin
          state    <= CLEAR;
          clr_addr <= '0;
          ready_q  <= 1'b0;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      vs_prev     <= 1'b1;
    end else begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // font_line answers for char_code/font_row, so stage 2 pairs it with stage-1 side-band.
  assign cursor_on = cursor_en && hit1 && blink_phase && (font_row >= CUR_ROW);
  assign pix_bit   = font_line[3'd7 - x1] ^ cursor_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0; y0 <= '0; von0 <= 1'b0; hs0 <= 1'b1; vs0 <= 1'b1; hit0 <= 1'b0;
      x1 <= '0; von1 <= 1'b0; hs1 <= 1'b1; vs1 <= 1'b1; hit1 <= 1'b0;
      char_code <= '0;
      font_row  <= '0;
      rgb       <= BG;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      x0   <= pix_x[2:0];
      y0   <= pix_y[YB-1:0];
      von0 <= video_on;
      hs0  <= hsync_in;
      vs0  <= vsync_in;
      hit0 <= (rd_addr == cursor_addr);

      char_code <= rd_data;
      font_row  <= 4'(y0);
      x1   <= x0;
      von1 <= von0;
      hs1  <= hs0;
      vs1  <= vs0;
      hit1 <= hit0;

      rgb       <= von1 ? (pix_bit ? FG : BG) : 12'h000;
      hsync_out <= hs1;
      vsync_out <= vs1;
    end
  end
endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer with a behavioural font_rom model.
module tb_text_renderer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic        cursor_en = 1'b0;
  logic [11:0] cursor_addr = '0;
  logic [7:0]  char_code, font_line;
  logic [3:0]  font_row;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int n_vec = 0;
  int n_miss = 0;

  text_renderer_if #(.ADDR_W(12)) wr_bus ();

  text_renderer #(
    .COLS(80), .ROWS(30), .CHAR_H(16), .FG(12'hFFF), .BG(12'h000),
    .BLINK_FRAMES(32), .ADDR_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr(wr_bus.slave),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr), .char_code(char_code),
    .font_row(font_row), .font_line(font_line), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [7:0] c, input logic [3:0] r);
    if (c == 8'h41) return (r == 4'd0) ? 8'h18 : 8'h66;
    return 8'h00;
  endfunction

  assign font_line = glyph(char_code, font_row);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_cell(input logic [11:0] a, input logic [7:0] d);
    wr_bus.wr_en = 1'b1; wr_bus.wr_addr = a; wr_bus.wr_data = d;
    step();
    wr_bus.wr_en = 1'b0;
  endtask

  task automatic read_cell(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] exp);
    pix_x = x; pix_y = y;
    step(2);
    check_val(tag, char_code, exp);
  endtask

  task automatic pix_check(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [11:0] exp);
    pix_x = x; pix_y = y; video_on = 1'b1;
    step(3);
    check_val(tag, rgb, exp);
  endtask

  task automatic vsync_falls(input int n);
    repeat (n) begin
      vsync_in = 1'b0; step();
      vsync_in = 1'b1; step();
    end
  endtask

  logic [11:0] scan_exp [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                                12'hFFF, 12'h000, 12'h000, 12'h000};
  logic [1:0]  sync_pat [8] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};

  initial begin
    int n;
    wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0; wr_bus.clear_req = 1'b0;

    #12;
    check_val("rst_rgb", rgb, 12'h000);
    check_val("rst_hs", hsync_out, 1);
    check_val("rst_vs", vsync_out, 1);
    check_val("rst_char", char_code, 0);
    check_val("rst_row", font_row, 0);
    check_val("rst_ready", wr_bus.wr_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // glyph scan of cell 0, row 0
    write_cell(12'd0, 8'h41);
    for (int k = 0; k < 11; k++) begin
      if (k >= 3) check_val($sformatf("scan_x%0d", k - 3), rgb, scan_exp[k - 3]);
      pix_y = 10'd0;
      if (k < 8) begin pix_x = 10'(k); video_on = 1'b1; end
      else video_on = 1'b0;
      step();
    end

    // sync pass-through with blanking at a foreground pixel
    // (this vsync pattern leaves 2 falls on the blink counter; a reset clears it later)
    pix_x = 10'd3; pix_y = 10'd0;
    for (int k = 0; k < 11; k++) begin
      if (k >= 3) begin
        check_val($sformatf("hs_%0d", k - 3), hsync_out, sync_pat[k - 3][1]);
        check_val($sformatf("vs_%0d", k - 3), vsync_out, sync_pat[k - 3][0]);
        check_val($sformatf("blank_%0d", k - 3), rgb, 12'h000);
      end
      video_on = 1'b0;
      if (k < 8) {hsync_in, vsync_in} = sync_pat[k];
      else {hsync_in, vsync_in} = 2'b11;
      step();
    end

    // full clear sweep
    wr_bus.clear_req = 1'b1; step(); wr_bus.clear_req = 1'b0;
    n = 0;
    while (wr_bus.wr_ready == 1'b0 && n < 3000) begin
      n++;
      if (n == 100) begin
        wr_bus.wr_en = 1'b1; wr_bus.wr_addr = 12'd5; wr_bus.wr_data = 8'h41;
        wr_bus.clear_req = 1'b1;
      end else begin
        wr_bus.wr_en = 1'b0; wr_bus.clear_req = 1'b0;
      end
      step();
    end
    wr_bus.wr_en = 1'b0; wr_bus.clear_req = 1'b0;
    check_val("clear_len", n, 2400);
    read_cell("clr_a0", 10'd0, 10'd0, 8'h20);
    read_cell("clr_a2399", 10'd632, 10'd464, 8'h20);
    read_cell("clr_a5", 10'd40, 10'd0, 8'h20);
    read_cell("font_row", 10'd0, 10'd3, 8'h20);
    check_val("font_row_val", font_row, 4'd3);

    // read-first collision on addr 81
    pix_x = 10'd8; pix_y = 10'd16;
    wr_bus.wr_en = 1'b1; wr_bus.wr_addr = 12'd81; wr_bus.wr_data = 8'h41;
    step();
    wr_bus.wr_en = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
    step();
    check_val("rdfirst_old", char_code, 8'h20);
    read_cell("rdfirst_new", 10'd8, 10'd16, 8'h41);

    // reset in the middle of a clear sweep
    write_cell(12'd2, 8'h41);
    write_cell(12'd2000, 8'h41);
    wr_bus.clear_req = 1'b1; step(); wr_bus.clear_req = 1'b0;
    pix_x = 10'd11; pix_y = 10'd16; video_on = 1'b1; hsync_in = 1'b0;
    step(10);
    check_val("pre_rst_rgb", rgb, 12'hFFF);
    check_val("pre_rst_ready", wr_bus.wr_ready, 0);
    rst_n = 1'b0; #1;
    check_val("arst_rgb", rgb, 12'h000);
    check_val("arst_hs", hsync_out, 1);
    check_val("arst_char", char_code, 0);
    check_val("arst_ready", wr_bus.wr_ready, 1);
    @(negedge clk); rst_n = 1'b1; hsync_in = 1'b1;
    step();
    check_val("post_rst_ready", wr_bus.wr_ready, 1);
    read_cell("partial_a2", 10'd16, 10'd0, 8'h20);
    read_cell("partial_a2000", 10'd0, 10'd400, 8'h41);

    // blinking cursor on cell 0 (space)
    cursor_en = 1'b1; cursor_addr = 12'd0;
    pix_check("cur_ph0_r15", 10'd2, 10'd15, 12'h000);
    vsync_falls(31);
    pix_check("cur_31_r15", 10'd2, 10'd15, 12'h000);
    vsync_falls(1);
    pix_check("cur_32_r14", 10'd2, 10'd14, 12'hFFF);
    pix_check("cur_32_r15", 10'd5, 10'd15, 12'hFFF);
    pix_check("cur_32_r13", 10'd2, 10'd13, 12'h000);
    pix_check("cur_32_r0", 10'd2, 10'd0, 12'h000);
    pix_check("cur_32_cell1", 10'd10, 10'd14, 12'h000);
    vsync_falls(32);
    pix_check("cur_64_r15", 10'd2, 10'd15, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Character-cell text renderer for the VGA path; sits directly upstream of font_rom and consumes its output.
- Takes raster coordinates from the video timing generator and holds an 80x30 character buffer.
- Drives char_code/row into font_rom, selects the addressed glyph bit, and emits RGB plus delay-matched syncs.
- Also provides a blinking block cursor and a buffer-clear sequencer.

Parameters:
- COLS, 80, text columns
- ROWS, 30, text rows
- CHAR_H, 16, pixel rows per cell (power of two; glyph width fixed at 8)
- FG, 12'hFFF, foreground RGB444
- BG, 12'h000, background RGB444
- BLINK_FRAMES, 32, frames per cursor blink half-period
- ADDR_W, 12, buffer address width (must satisfy 2^ADDR_W >= COLS*ROWS)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- video_on  in  1  active-area flag
- hsync_in  in  1  horizontal sync from timing generator
- vsync_in  in  1  vertical sync, active-low
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  cell address (row*COLS+col)
- wr_data  in  8  character code
- wr_ready  out  1  high when writes are accepted
- clear_req  in  1  pulse: fill buffer with 8'h20
- cursor_en  in  1  enable cursor
- cursor_addr  in  ADDR_W  cursor cell
- char_code  out  8  to font_rom
- font_row  out  4  to font_rom row
- font_line  in  8  from font_rom (combinational)
- rgb  out  12  pixel colour
- hsync_out  out  1  hsync delayed to match rgb
- vsync_out  out  1  vsync delayed to match rgb

Behaviour:
- Reset (async, rst_n low): rgb=BG, hsync_out=1, vsync_out=1, char_code=0, font_row=0, wr_ready=1, FSM=IDLE, blink counter=0, blink phase=0. Buffer contents are not reset.
- Stage 0 (register inputs): cell address = (pix_y/CHAR_H)*COLS + pix_x[9:3]. Synchronous buffer read. Capture x[2:0], y%CHAR_H, video_on, syncs, and a cursor-hit flag (address==cursor_addr).
- Stage 1: char_code = buffer read data; font_row = y%CHAR_H truncated to 4 bits. Side-band signals delayed in step.
- Stage 2: bit = font_line[7 - x[2:0]] (MSB is the leftmost pixel).
  - Cursor inverts bit when: cursor_en, cursor-hit, blink phase=1, and font_row >= CHAR_H-2.
  - rgb = (video_on ? (bit ? FG : BG) : 12'h000).
- Latency: pix_x/pix_y/syncs to rgb/hsync_out/vsync_out is exactly 3 clocks. Syncs pass through unaltered, only delayed.
- Buffer: COLS*ROWS entries, one write port and one read port. A write and a read to the same address in the same cycle returns old data (read-first).
- Writes are honoured only when wr_ready=1. Writes with wr_addr >= COLS*ROWS are ignored.
- Clear FSM:
  - IDLE -> CLEAR on clear_req. Write address is set to 0 and wr_ready drops in the next cycle.
  - CLEAR writes 8'h20 each cycle, address+1.
  - Exits to IDLE after writing address COLS*ROWS-1, so the sweep lasts COLS*ROWS cycles; wr_ready returns to 1 the cycle after the last write.
  - clear_req during CLEAR is ignored. External writes during CLEAR are dropped.
  - Rendering continues during CLEAR.
- Blink: the frame counter increments on each vsync_in falling edge. On reaching BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
- Reset asserted mid-CLEAR aborts the sweep; cells already cleared stay cleared, the rest keep old contents.
- Pixel coordinates beyond COLS*8 / ROWS*CHAR_H only occur with video_on=0. The computed address may then be out of range; the read result is don't-care, but rgb must be 0.

Decomposition:
- Shared video package holds: H_ACTIVE=640, V_ACTIVE=480, GLYPH_W=8, SPACE_CHAR=8'h20, and the RGB444 colour type.
- Natural sub-module: text_buffer_ram (dual-port, read-first, synchronous read, no reset).
- The clear FSM, pipeline and blink logic remain in text_renderer.
- font_rom is instantiated by the parent, not inside this block.

Test Plan:
- Write 8'h41 ('A') at addr 0. Scan y=0, x=0..7 with video_on=1 and the bench modelling font_rom "A" row 0 = 00011000 -> rgb from 3 clocks later = BG,BG,BG,FG,FG,BG,BG,BG.
- Drive the hsync_in/vsync_in toggle pattern -> hsync_out/vsync_out reproduce it exactly 3 clocks later. video_on=0 at any position -> rgb=12'h000.
- Pulse clear_req -> wr_ready low for exactly 2400 cycles. Read back addr 0 and 2399 (via rendered char_code) = 8'h20. A wr_en issued mid-clear to addr 5 leaves addr 5 = 8'h20.
- cursor_en=1, cursor_addr=0, cell holds 8'h20, after 32 vsync falls -> rows 14-15 of cell 0 show FG. After 64 falls -> back to BG. Rows 0-13 stay BG throughout.
- Write 8'h41 to addr 81 on the same cycle stage 0 reads addr 81 -> that pass shows the old char; the next frame shows 'A'.
- Assert rst_n low for 1 cycle mid-CLEAR -> all outputs take their reset values immediately (async) and wr_ready=1 after release.
